// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement adder/subtractor: WIDTH bits split into STAGES chunks,
// one chunk rippled per stage, valid/ready handshake with full backpressure.
module pipelined_addsub #(
  parameter int WIDTH  = 64,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int CHUNK = WIDTH / STAGES;

  logic [STAGES-1:0] stg_valid;
  logic [STAGES-1:0] stg_carry;
  logic [STAGES-1:0] nxt_carry;
  logic [STAGES-1:0] load;
  logic [STAGES-1:0] adv;
  logic [WIDTH-1:0]  stg_a   [STAGES];
  logic [WIDTH-1:0]  stg_b   [STAGES];
  logic [WIDTH-1:0]  stg_sum [STAGES];
  logic [WIDTH-1:0]  nxt_a   [STAGES];
  logic [WIDTH-1:0]  nxt_b   [STAGES];
  logic [WIDTH-1:0]  nxt_sum [STAGES];
  logic              fin_ovf;
  logic              ovf_q;
  logic              zero_q;

  // Advance chain runs from the output back to stage 0, so a drain at the
  // output frees every full stage behind it in the same cycle.
  always_comb begin
    logic free;
    free = out_ready;
    adv  = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      adv[k] = stg_valid[k] && free;
      free   = !stg_valid[k] || free;
    end
    in_ready = free;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [WIDTH-1:0] src_sum;
    logic             src_c;
    logic [CHUNK:0]   part;

    if (k == 0) begin : g_first
      assign src_a   = a;
      assign src_b   = b ^ {WIDTH{sub}};
      assign src_sum = '0;
      assign src_c   = cin ^ sub;
      assign load[k] = in_valid && in_ready;
    end else begin : g_next
      assign src_a   = stg_a[k-1];
      assign src_b   = stg_b[k-1];
      assign src_sum = stg_sum[k-1];
      assign src_c   = stg_carry[k-1];
      assign load[k] = adv[k-1];
    end

    assign part = {1'b0, src_a[k*CHUNK +: CHUNK]} + {1'b0, src_b[k*CHUNK +: CHUNK]}
                + {{CHUNK{1'b0}}, src_c};
    assign nxt_a[k]     = src_a;
    assign nxt_b[k]     = src_b;
    assign nxt_carry[k] = part[CHUNK];
    // Unsummed chunks of the partial sum are still zero, so OR merges the new chunk.
    assign nxt_sum[k]   = src_sum | (WIDTH'(part[CHUNK-1:0]) << (k * CHUNK));

    if (k == STAGES - 1) begin : g_last
      assign fin_ovf = src_a[WIDTH-1] ^ src_b[WIDTH-1] ^ nxt_sum[k][WIDTH-1] ^ part[CHUNK];
    end
  end

  // A stage captures a beat when its upstream advances, and empties when it
  // hands its beat on without a replacement; data is held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_valid <= '0;
      stg_carry <= '0;
      ovf_q     <= 1'b0;
      zero_q    <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        stg_a[k]   <= '0;
        stg_b[k]   <= '0;
        stg_sum[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (load[k]) begin
          stg_valid[k] <= 1'b1;
          stg_a[k]     <= nxt_a[k];
          stg_b[k]     <= nxt_b[k];
          stg_sum[k]   <= nxt_sum[k];
          stg_carry[k] <= nxt_carry[k];
        end else if (adv[k]) begin
          stg_valid[k] <= 1'b0;
        end
      end
      if (load[STAGES-1]) begin
        ovf_q  <= fin_ovf;
        zero_q <= (nxt_sum[STAGES-1] == '0);
      end
    end
  end

  assign out_valid = stg_valid[STAGES-1];
  assign sum       = stg_sum[STAGES-1];
  assign cout      = stg_carry[STAGES-1];
  assign overflow  = ovf_q;
  assign zero      = zero_q;
  assign negative  = stg_sum[STAGES-1][WIDTH-1];

endmodule
